// File: rtl/cnn_layer_accel_pkg.sv
// cnn_layer_accel_pkg: shared sequence-word fields, default sizes, FSM states and clog2
package cnn_layer_accel_pkg;

    localparam int SEQ_S        = 13;
    localparam int SEQ_RM       = 12;
    localparam int SEQ_RST      = 11;
    localparam int SEQ_P        = 10;
    localparam int SEQ_FIELD_HI = 9;
    localparam int SEQ_FIELD_LO = 0;

    localparam int DEF_NUM_AWE        = 4;
    localparam int DEF_PIXEL_WIDTH    = 16;
    localparam int DEF_BRAM_DEPTH     = 1024;
    localparam int DEF_SEQ_DATA_WIDTH = 14;

    typedef enum logic [1:0] {IDLE, SEQ_LOAD, PIX_LOAD, ACTIVE} state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/cnn_octo_bram_ctrl.sv
// cnn_octo_bram_ctrl: map config, load/pass counters, bank-full flags, FSM and BRAM address generation
module cnn_octo_bram_ctrl
    import cnn_layer_accel_pkg::*;
#(
    parameter int C_BRAM_DEPTH = DEF_BRAM_DEPTH,
    localparam int AW = clog2(C_BRAM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          new_map_i,
    input  logic [9:0]    num_rows_i,
    input  logic [9:0]    num_cols_i,
    input  logic [AW:0]   seq_full_count_i,
    input  logic          datain_valid_i,
    input  logic          seq_tag_i,
    input  logic          pixel_tag_i,
    input  logic [AW-1:0] seq_addr_i,
    output logic          seq_rdy_o,
    output logic          pixel_rdy_o,
    output logic          seq_we_o,
    output logic [AW-1:0] seq_wr_addr_o,
    output logic          pix_we_o,
    output logic [AW-1:0] pix_wr_addr_o,
    output logic [AW-1:0] seq_rd_addr_o,
    output logic          pix_rd_en_o,
    output logic [AW-1:0] pix_rd_addr_o,
    output logic          map_done_o
);

    state_t        state_q, state_d;
    logic [9:0]    num_rows_q, num_rows_d;
    logic [9:0]    num_cols_q, num_cols_d;
    logic [AW:0]   seq_cnt_q, seq_cnt_d;
    logic [AW:0]   seq_wr_ptr_q, seq_wr_ptr_d;
    logic [AW-1:0] seq_rd_ptr_q, seq_rd_ptr_d;
    logic [9:0]    col_q, col_d;
    logic [10:0]   wr_row_q, wr_row_d;
    logic [9:0]    base_row_q, base_row_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          map_done_q, map_done_d;
    logic          seq_acc, pix_acc, rows_pending, last_entry, row_end;

    assign rows_pending  = wr_row_q <= {1'b0, num_rows_q};
    assign seq_rdy_o     = state_q == SEQ_LOAD;
    assign pixel_rdy_o   = (state_q == PIX_LOAD || state_q == ACTIVE) && !bank_full_q[wr_row_q[0]] && rows_pending;
    assign seq_acc       = seq_rdy_o && datain_valid_i && seq_tag_i;
    assign pix_acc       = pixel_rdy_o && datain_valid_i && pixel_tag_i;
    assign last_entry    = {1'b0, seq_rd_ptr_q} == seq_cnt_q - 1'b1;
    assign row_end       = col_q == num_cols_q;
    assign seq_we_o      = seq_acc && !new_map_i;
    assign seq_wr_addr_o = seq_wr_ptr_q[AW-1:0];
    assign pix_we_o      = pix_acc && !new_map_i;
    assign pix_wr_addr_o = {wr_row_q[0], col_q[AW-2:0]};
    assign seq_rd_addr_o = seq_rd_ptr_q;
    assign pix_rd_en_o   = state_q == ACTIVE && !new_map_i;
    assign pix_rd_addr_o = {seq_addr_i[AW-1] ^ base_row_q[0], seq_addr_i[AW-2:0]};
    assign map_done_o    = map_done_q;

    // next state: loading, pass sequencing and bank bookkeeping; new_map overrides everything
    always_comb begin
        state_d      = state_q;
        num_rows_d   = num_rows_q;
        num_cols_d   = num_cols_q;
        seq_cnt_d    = seq_cnt_q;
        seq_wr_ptr_d = seq_wr_ptr_q;
        seq_rd_ptr_d = seq_rd_ptr_q;
        col_d        = col_q;
        wr_row_d     = wr_row_q;
        base_row_d   = base_row_q;
        bank_full_d  = bank_full_q;
        map_done_d   = 1'b0;
        if (seq_acc) begin
            seq_wr_ptr_d = seq_wr_ptr_q + 1'b1;
            if (seq_wr_ptr_d == seq_cnt_q) state_d = PIX_LOAD;
        end
        if (pix_acc) begin
            col_d = row_end ? '0 : col_q + 1'b1;
            if (row_end) begin
                bank_full_d[wr_row_q[0]] = 1'b1;
                wr_row_d                 = wr_row_q + 1'b1;
            end
        end
        if (state_q == PIX_LOAD) begin
            if (base_row_q == num_rows_q && !rows_pending) begin
                state_d    = IDLE;
                map_done_d = 1'b1;
            end else if (&bank_full_q && base_row_q < num_rows_q) begin
                state_d = ACTIVE;
            end
        end
        if (state_q == ACTIVE) begin
            seq_rd_ptr_d = last_entry ? '0 : seq_rd_ptr_q + 1'b1;
            if (last_entry) begin
                bank_full_d[base_row_q[0]] = 1'b0;
                base_row_d                 = base_row_q + 1'b1;
                state_d                    = PIX_LOAD;
            end
        end
        if (new_map_i) begin
            state_d      = SEQ_LOAD;
            num_rows_d   = num_rows_i;
            num_cols_d   = num_cols_i;
            seq_cnt_d    = seq_full_count_i;
            seq_wr_ptr_d = '0;
            seq_rd_ptr_d = '0;
            col_d        = '0;
            wr_row_d     = '0;
            base_row_d   = '0;
            bank_full_d  = '0;
            map_done_d   = 1'b0;
        end
    end

    // state and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            num_rows_q   <= '0;
            num_cols_q   <= '0;
            seq_cnt_q    <= '0;
            seq_wr_ptr_q <= '0;
            seq_rd_ptr_q <= '0;
            col_q        <= '0;
            wr_row_q     <= '0;
            base_row_q   <= '0;
            bank_full_q  <= '0;
            map_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_rows_q   <= num_rows_d;
            num_cols_q   <= num_cols_d;
            seq_cnt_q    <= seq_cnt_d;
            seq_wr_ptr_q <= seq_wr_ptr_d;
            seq_rd_ptr_q <= seq_rd_ptr_d;
            col_q        <= col_d;
            wr_row_q     <= wr_row_d;
            base_row_q   <= base_row_d;
            bank_full_q  <= bank_full_d;
            map_done_q   <= map_done_d;
        end
    end

endmodule

// File: rtl/cnn_octo_layer_accel.sv
// cnn_octo_layer_accel: sequence table + ping-pong pixel BRAM front end feeding the AWE array
module cnn_octo_layer_accel
    import cnn_layer_accel_pkg::*;
#(
    parameter int C_NUM_AWE        = DEF_NUM_AWE,
    parameter int C_PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
    parameter int C_BRAM_DEPTH     = DEF_BRAM_DEPTH,
    parameter int C_SEQ_DATA_WIDTH = DEF_SEQ_DATA_WIDTH,
    localparam int C_LOG2_BRAM_DEPTH = clog2(C_BRAM_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         new_map,
    input  logic [9:0]                   num_rows,
    input  logic [9:0]                   num_cols,
    input  logic [C_LOG2_BRAM_DEPTH:0]   seq_full_count,
    input  logic [C_PIXEL_WIDTH-1:0]     datain,
    input  logic                         datain_valid,
    input  logic                         seq_datain_tag,
    output logic                         seq_datain_rdy,
    input  logic                         pixel_datain_tag,
    output logic                         pixel_datain_rdy,
    output logic [C_PIXEL_WIDTH-1:0]     pixel_dataout,
    output logic [3:0]                   pixel_dataout_flags,
    output logic                         pixel_dataout_valid,
    output logic                         map_done
);

    localparam int AW = C_LOG2_BRAM_DEPTH;

    logic [C_SEQ_DATA_WIDTH-1:0] seq_mem [C_BRAM_DEPTH];
    logic [C_PIXEL_WIDTH-1:0]    pix_mem [C_BRAM_DEPTH];
    logic [C_SEQ_DATA_WIDTH-1:0] seq_word;
    logic                        seq_we, pix_we, rd_en;
    logic [AW-1:0]               seq_wr_addr, pix_wr_addr, seq_rd_addr, pix_rd_addr;
    logic [C_PIXEL_WIDTH-1:0]    dout_q;
    logic [3:0]                  flags_q;
    logic                        valid_q;

    cnn_octo_bram_ctrl #(
        .C_BRAM_DEPTH (C_BRAM_DEPTH)
    ) u_ctrl (
        .clk_i            (clk),
        .rst_i            (rst),
        .new_map_i        (new_map),
        .num_rows_i       (num_rows),
        .num_cols_i       (num_cols),
        .seq_full_count_i (seq_full_count),
        .datain_valid_i   (datain_valid),
        .seq_tag_i        (seq_datain_tag),
        .pixel_tag_i      (pixel_datain_tag),
        .seq_addr_i       (seq_word[AW-1:0]),
        .seq_rdy_o        (seq_datain_rdy),
        .pixel_rdy_o      (pixel_datain_rdy),
        .seq_we_o         (seq_we),
        .seq_wr_addr_o    (seq_wr_addr),
        .pix_we_o         (pix_we),
        .pix_wr_addr_o    (pix_wr_addr),
        .seq_rd_addr_o    (seq_rd_addr),
        .pix_rd_en_o      (rd_en),
        .pix_rd_addr_o    (pix_rd_addr),
        .map_done_o       (map_done)
    );

    assign seq_word            = seq_mem[seq_rd_addr];
    assign pixel_dataout       = dout_q;
    assign pixel_dataout_flags = flags_q;
    assign pixel_dataout_valid = valid_q;

    // sequence table and pixel bank writes
    always_ff @(posedge clk) begin
        if (seq_we) seq_mem[seq_wr_addr] <= datain[C_SEQ_DATA_WIDTH-1:0];
        if (pix_we) pix_mem[pix_wr_addr] <= datain;
    end

    // one-cycle pixel read, with the entry flags carried alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                dout_q  <= pix_mem[pix_rd_addr];
                flags_q <= seq_word[SEQ_S:SEQ_P];
            end
        end
    end

endmodule

// File: tb/tb_cnn_octo_layer_accel.sv
// tb_cnn_octo_layer_accel: directed map sequence with random tables checked against a row-pair model
module tb_cnn_octo_layer_accel;

    logic        clk = 1'b0;
    logic        rst, new_map;
    logic [9:0]  num_rows, num_cols;
    logic [10:0] seq_full_count;
    logic [15:0] datain;
    logic        datain_valid, seq_datain_tag, pixel_datain_tag;
    logic        seq_datain_rdy, pixel_datain_rdy, pixel_dataout_valid, map_done;
    logic [15:0] pixel_dataout;
    logic [3:0]  pixel_dataout_flags;

    int          n_assert = 0;
    int          n_fail = 0;
    int          m_r, m_c, m_n;
    logic [13:0] tbl [0:1023];
    logic [15:0] pix [0:31][0:31];
    logic [19:0] got [0:1023];
    logic [19:0] exp_q [$];

    cnn_octo_layer_accel dut (
        .clk                 (clk),
        .rst                 (rst),
        .new_map             (new_map),
        .num_rows            (num_rows),
        .num_cols            (num_cols),
        .seq_full_count      (seq_full_count),
        .datain              (datain),
        .datain_valid        (datain_valid),
        .seq_datain_tag      (seq_datain_tag),
        .seq_datain_rdy      (seq_datain_rdy),
        .pixel_datain_tag    (pixel_datain_tag),
        .pixel_datain_rdy    (pixel_datain_rdy),
        .pixel_dataout       (pixel_dataout),
        .pixel_dataout_flags (pixel_dataout_flags),
        .pixel_dataout_valid (pixel_dataout_valid),
        .map_done            (map_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic start_map(input int r, input int c, input int n);
        @(negedge clk);
        datain_valid     = 1'b0;
        seq_datain_tag   = 1'b0;
        pixel_datain_tag = 1'b0;
        num_rows         = 10'(r);
        num_cols         = 10'(c);
        seq_full_count   = 11'(n);
        new_map          = 1'b1;
        m_r = r;
        m_c = c;
        m_n = n;
        @(negedge clk);
        new_map = 1'b0;
    endtask

    // random table/pixels; expected stream: pass p, entry e -> pix[p + bank][col] with entry flags
    task automatic gen_tables(input bit directed);
        logic [13:0] w;
        exp_q.delete();
        for (int e = 0; e < m_n; e++) begin
            w[13:10] = 4'($urandom_range(0, 15));
            w[9]     = 1'($urandom_range(0, 1));
            w[8:0]   = 9'($urandom_range(0, m_c));
            tbl[e]   = w;
        end
        if (directed) begin
            tbl[0] = 14'h0800;
            tbl[1] = 14'h0002;
            tbl[2] = 14'h2200;
            tbl[3] = 14'h0201;
            tbl[4] = 14'h1202;
        end
        for (int i = 0; i <= m_r; i++)
            for (int j = 0; j <= m_c; j++)
                pix[i][j] = 16'($urandom_range(1, 10));
        for (int p = 0; p < m_r; p++)
            for (int e = 0; e < m_n; e++) begin
                w = tbl[e];
                exp_q.push_back({w[13:10], pix[p + int'(w[9])][w[8:0]]});
            end
    endtask

    task automatic load_seq();
        int acc = 0;
        for (int cyc = 0; acc < m_n && cyc < 4 * m_n + 10; cyc++) begin
            check("seq_rdy_high", seq_datain_rdy, 1);
            check("pix_rdy_during_seq", pixel_datain_rdy, 0);
            datain_valid     = 1'b1;
            pixel_datain_tag = 1'b0;
            seq_datain_tag   = (cyc != 2);
            datain           = (cyc == 2) ? 16'h3fff : {2'b00, tbl[acc]};
            if (seq_datain_tag) acc++;
            @(negedge clk);
        end
        datain_valid   = 1'b0;
        seq_datain_tag = 1'b0;
        check("seq_accepts", acc, m_n);
        check("seq_rdy_low_after_load", seq_datain_rdy, 0);
        check("pix_rdy_after_seq", pixel_datain_rdy, 1);
    endtask

    task automatic load_pix();
        int idx = 0;
        int outs = 0;
        int dones = 0;
        int full2 = 2 * (m_c + 1);
        int total = (m_r + 1) * (m_c + 1);
        bit low_seen = 0;
        bit rise_chk = 0;
        logic [19:0] e;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (pixel_dataout_valid) begin
                if (exp_q.size() == 0) check("extra_output", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("out_pixel", pixel_dataout, e[15:0]);
                    check("out_flags", pixel_dataout_flags, e[19:16]);
                    if (outs < 1024) got[outs] = {pixel_dataout_flags, pixel_dataout};
                end
                outs++;
            end
            if (map_done) dones++;
            if (dones != 0) break;
            if (idx == full2 && idx < total && !low_seen) begin
                check("rdy_low_both_banks_full", pixel_datain_rdy, 0);
                low_seen = 1;
            end else if (low_seen && !rise_chk && pixel_datain_rdy) begin
                check("rdy_rise_at_pass0_end", outs, m_n);
                rise_chk = 1;
            end
            seq_datain_tag = 1'b0;
            if (idx < total) begin
                datain           = pix[idx / (m_c + 1)][idx % (m_c + 1)];
                datain_valid     = 1'b1;
                pixel_datain_tag = 1'b1;
                if (pixel_datain_rdy) idx++;
            end else begin
                datain_valid     = 1'b0;
                pixel_datain_tag = 1'b0;
            end
            @(negedge clk);
        end
        datain_valid     = 1'b0;
        pixel_datain_tag = 1'b0;
        check("map_done_pulse", dones, 1);
        check("pixels_accepted", idx, total);
        check("output_count", outs, m_r * m_n);
        @(negedge clk);
        check("map_done_single", map_done, 0);
        check("idle_valid", pixel_dataout_valid, 0);
        check("idle_seq_rdy", seq_datain_rdy, 0);
        check("idle_pix_rdy", pixel_datain_rdy, 0);
    endtask

    initial begin
        rst = 1'b1;
        new_map = 1'b0;
        num_rows = '0;
        num_cols = '0;
        seq_full_count = '0;
        datain = '0;
        datain_valid = 1'b0;
        seq_datain_tag = 1'b0;
        pixel_datain_tag = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_seq_rdy", seq_datain_rdy, 0);
            check("rst_pix_rdy", pixel_datain_rdy, 0);
            check("rst_valid", pixel_dataout_valid, 0);
            check("rst_map_done", map_done, 0);
            check("rst_dataout", pixel_dataout, 0);
            check("rst_flags", pixel_dataout_flags, 0);
        end
        rst = 1'b0;
        // 10x10 map, 50-entry table with directed head entries
        start_map(9, 9, 50);
        gen_tables(1);
        load_seq();
        load_pix();
        check("p0_e0_pix", got[0][15:0], pix[0][0]);
        check("p0_e0_flags_rst", got[0][19:16], 4'b0010);
        check("p0_e1_pix", got[1][15:0], pix[0][2]);
        check("p0_e2_pix", got[2][15:0], pix[1][0]);
        check("p0_e2_flags_s", got[2][19:16], 4'b1000);
        check("p0_e3_pix", got[3][15:0], pix[1][1]);
        check("p0_e4_pix", got[4][15:0], pix[1][2]);
        check("p0_e4_flags_rm", got[4][19:16], 4'b0100);
        check("p1_e2_pix_bank_swap", got[52][15:0], pix[2][0]);
        // abort a map while its first pass is streaming out
        start_map(3, 3, 6);
        gen_tables(0);
        load_seq();
        for (int cyc = 0; cyc < 100 && !pixel_dataout_valid; cyc++) begin
            datain           = 16'h00aa;
            datain_valid     = 1'b1;
            pixel_datain_tag = 1'b1;
            @(negedge clk);
        end
        check("abort_pass_running", pixel_dataout_valid, 1);
        start_map(1, 3, 4);
        check("abort_seq_rdy", seq_datain_rdy, 1);
        check("abort_pix_rdy", pixel_datain_rdy, 0);
        check("abort_no_stale_valid", pixel_dataout_valid, 0);
        check("abort_no_done", map_done, 0);
        gen_tables(0);
        load_seq();
        load_pix();
        // single-row map: no pass, done after the row loads
        start_map(0, 4, 3);
        gen_tables(0);
        load_seq();
        load_pix();
        // random-geometry map
        start_map(4, int'($urandom_range(2, 12)), int'($urandom_range(5, 20)));
        gen_tables(0);
        load_seq();
        load_pix();
        // asynchronous reset mid-map
        start_map(2, 2, 3);
        gen_tables(0);
        load_seq();
        rst = 1'b1;
        #1;
        check("midrst_pix_rdy", pixel_datain_rdy, 0);
        check("midrst_seq_rdy", seq_datain_rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle_seq_rdy", seq_datain_rdy, 0);
        check("midrst_idle_valid", pixel_dataout_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
